// File: rtl/alu_result_buffer.sv
// Result FIFO between the ALU and writeback: buffers result/flags/dest tags and
// tracks accepted signed-overflow results in a sticky flag and saturating counter.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  input  logic [2:0]               in_command,
  input  logic [4:0]               in_dest,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [4:0]               out_dest,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf_sticky,
  output logic [7:0]               ovf_count,
  input  logic                     clr_sticky
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [4:0]  dest;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          ovf_qual;
  logic          ovf_push;

  // Handshakes and head decode; overflow is only meaningful for ADD/SUB
  always_comb begin
    in_ready  = !reset && (level < LW'(DEPTH));
    out_valid = (level != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    ovf_qual  = in_overflow && ((in_command == 3'd0) || (in_command == 3'd1));
    ovf_push  = push && ovf_qual;

    wr_entry.result   = in_result;
    wr_entry.zero     = in_zero;
    wr_entry.overflow = ovf_qual;
    wr_entry.dest     = in_dest;

    head         = mem[rd_ptr];
    out_result   = head.result;
    out_zero     = head.zero;
    out_overflow = head.overflow;
    out_dest     = head.dest;
  end

  // Storage is cleared on reset so the head fields read zero afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A clear coincident with an overflow push restarts the tally at one
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (clr_sticky) begin
      ovf_sticky <= ovf_push;
      ovf_count  <= ovf_push ? 8'd1 : 8'd0;
    end else if (ovf_push) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != 8'hFF) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: a queue-based model predicts acceptance,
// head contents and overflow statistics; a negedge monitor compares every cycle.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic        in_overflow;
  logic [2:0]  in_command;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic [4:0]  out_dest;
  logic [$clog2(DEPTH):0] level;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;
  logic        clr_sticky;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_overflow (in_overflow),
    .in_command  (in_command),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_overflow(out_overflow),
    .out_dest    (out_dest),
    .level       (level),
    .ovf_sticky  (ovf_sticky),
    .ovf_count   (ovf_count),
    .clr_sticky  (clr_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic [4:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int   m_count;
  logic m_sticky;
  logic rst_prev;
  int   n_cmp;
  int   n_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, req);
    end
  endtask

  // Monitor + reference model: compare state, then advance the model by the
  // handshake that the coming rising edge will perform.
  always @(negedge clk) begin
    int   sz;
    logic acc;
    logic qual;
    exp_t e;
    if (reset) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'(0));
      if (rst_prev) begin
        chk("level_reset", 32'(level), 32'(0));
        chk("out_valid_reset", 32'(out_valid), 32'(0));
        chk("out_result_reset", out_result, 32'(0));
        chk("out_zero_reset", 32'(out_zero), 32'(0));
        chk("out_overflow_reset", 32'(out_overflow), 32'(0));
        chk("out_dest_reset", 32'(out_dest), 32'(0));
        chk("ovf_sticky_reset", 32'(ovf_sticky), 32'(0));
        chk("ovf_count_reset", 32'(ovf_count), 32'(0));
      end
      exp_q.delete();
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      sz = exp_q.size();
      chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      chk("level", 32'(level), 32'(sz));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      chk("ovf_count", 32'(ovf_count), 32'(m_count));
      if (sz != 0) begin
        chk("out_result", out_result, exp_q[0].r);
        chk("out_zero", 32'(out_zero), 32'(exp_q[0].z));
        chk("out_overflow", 32'(out_overflow), 32'(exp_q[0].o));
        chk("out_dest", 32'(out_dest), 32'(exp_q[0].d));
      end
      acc  = in_valid && (sz < DEPTH);
      qual = in_overflow && (in_command == 3'd0 || in_command == 3'd1);
      if (sz != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        e.r = in_result;
        e.z = in_zero;
        e.o = qual;
        e.d = in_dest;
        exp_q.push_back(e);
      end
      if (clr_sticky) begin
        m_sticky = acc && qual;
        m_count  = (acc && qual) ? 1 : 0;
      end else if (acc && qual) begin
        m_sticky = 1'b1;
        m_count  = (m_count >= 255) ? 255 : m_count + 1;
      end
    end
    rst_prev = reset;
  end

  // Present one cycle of inputs, returning just after the edge that samples them
  task automatic step(input logic v, input logic [31:0] r, input logic z, input logic ov,
                      input logic [2:0] cmd, input logic [4:0] d, input logic ordy,
                      input logic clr);
    in_valid    = v;
    in_result   = r;
    in_zero     = z;
    in_overflow = ov;
    in_command  = cmd;
    in_dest     = d;
    out_ready   = ordy;
    clr_sticky  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, ordy, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    rst_prev = 1'b0;
    m_count  = 0;
    m_sticky = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_overflow = 1'b0;
    in_command = '0; in_dest = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single pass-through with consumer ready
    step(1'b1, 32'h5, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Overfill with consumer stalled, then drain in order
    for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 3'd5, 5'(i), 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 6);

    // Full with both sides active: only the pop happens
    for (int i = 0; i < 4; i++) step(1'b1, 32'(16 + i), 1'b1, 1'b0, 3'd2, 5'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 3'd0, 5'd9, 1'b1, 1'b0);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0, 3'd0, 5'd10, 1'b0, 1'b0);
    idle(1'b1, 6);

    // Overflow qualification by opcode
    step(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 3'd0, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'h1234, 1'b0, 1'b1, 3'd6, 5'd2, 1'b0, 1'b0);
    idle(1'b1, 4);

    // Saturation, then clear coincident with another overflow push
    for (int i = 0; i < 300; i++) step(1'b1, 32'(i), 1'b0, 1'b1, 3'(i % 2), 5'd1, 1'b1, 1'b0);
    idle(1'b1, 2);
    step(1'b1, 32'h99, 1'b0, 1'b1, 3'd1, 5'd4, 1'b1, 1'b1);
    idle(1'b1, 2);
    step(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Reset with three entries stored, competing with push/pop/clear
    for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b1, 3'd0, 5'(i), 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 32'h55, 1'b1, 1'b1, 3'd0, 5'd7, 1'b1, 1'b1);
    step(1'b1, 32'h56, 1'b1, 1'b1, 3'd0, 5'd7, 1'b1, 1'b0);
    reset = 1'b0;
    idle(1'b1, 2);

    // Randomised traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      step(1'($urandom_range(0, 2) != 0), $urandom(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 3) == 0 ? 0 : 1), 1'($urandom_range(0, 49) == 0));
    end
    reset = 1'b0;
    idle(1'b1, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU result present.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 in_result  input  32  ALU result word.
REQ-007 in_zero  input  1  ALU zero flag.
REQ-008 in_overflow  input  1  ALU overflow flag.
REQ-009 in_command  input  3  ALU opcode: 0 ADD, 1 SUB, 2 NAND, 3 AND, 4 NOR, 5 OR, 6 XOR, 7 SLT.
REQ-010 in_dest  input  5  destination register tag.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_result / out_zero / out_overflow / out_dest  output  32/1/1/5  head entry fields.
REQ-014 level  output  clog2(DEPTH)+1  current entry count.
REQ-015 ovf_sticky  output  1  an overflowing result has been accepted since last clear.
REQ-016 ovf_count  output  8  number of accepted overflowing results, saturating.
REQ-017 clr_sticky  input  1  clears ovf_sticky and ovf_count.

Function
REQ-018 Push SHALL occur on a cycle with in_valid=1 and in_ready=1; pop on a cycle with out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal (level < DEPTH) and reset=0; it SHALL NOT depend on out_ready (no pass-through when full).
REQ-020 out_valid SHALL equal (level != 0); no empty bypass: a push is visible at the output one cycle later.
REQ-021 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-022 Write and read pointers SHALL wrap modulo DEPTH.
REQ-023 Head fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Stored overflow SHALL equal in_overflow AND (in_command is 0 or 1); other opcodes store overflow 0.
REQ-025 in_zero, in_result, in_dest SHALL be stored unmodified.
REQ-026 ovf_sticky SHALL set on a push with qualified overflow 1 and clear on clr_sticky; if both occur in one cycle, it SHALL be 1.
REQ-027 ovf_count SHALL increment on each push with qualified overflow 1 and saturate at 255; clr_sticky SHALL zero it; if both occur in one cycle, it SHALL be 1.
REQ-028 Inputs presented with in_ready=0 SHALL be ignored, with no effect on the FIFO or counters.

Reset
REQ-029 Reset SHALL take priority over push, pop and clr_sticky.
REQ-030 After reset: level=0, pointers=0, out_valid=0, ovf_sticky=0, ovf_count=0, out_result=0, out_zero=0, out_overflow=0, out_dest=0.
REQ-031 in_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL discard all stored entries with no partial pop.

Verification
REQ-033 Push 0x00000005/ADD/dest 3, out_ready=1 -> out_valid=1 next cycle with out_result=5, out_dest=3; level returns to 0 after the pop.
REQ-034 DEPTH=4, out_ready=0, push 5 entries -> in_ready=0 after the 4th push; 5th ignored; drain returns entries 1-4 in order.
REQ-035 Full FIFO, in_valid=1, out_ready=1 -> one pop, no push that cycle; level goes 4 -> 3, then in_ready=1.
REQ-036 Push ADD ovf=1, then XOR ovf=1 -> out_overflow 1 then 0; ovf_count=1; ovf_sticky=1.
REQ-037 Push 300 ADD overflow entries -> ovf_count=255; clr_sticky coincident with another overflow push -> ovf_count=1, ovf_sticky=1.
REQ-038 Reset asserted with level=3 -> next cycle level=0, out_valid=0, in_ready=0; after deassert, in_ready=1.
